// File: rtl/ysyx_24070017_sram_responder.sv
// Purpose : memory-side responder for the core load/store port, backed by a word-organised SRAM at BASE_ADDR.
// Latency : rsp_valid rises LATENCY+1 cycles after the accept edge (plus 0..7 cycles with random delay enabled).
// Backpressure: one request in flight; req_ready is low from accept until the response handshake, and the
//               response (data/err) is held stable while rsp_ready is low.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-low reset
//   req_valid / req_ready    request handshake; req_wen, req_addr, req_wdata, req_wmask carry the request
//   rsp_valid / rsp_ready    response handshake; rsp_rdata (right-aligned load data), rsp_err (address miss)
//
// Optional: define YSYX_24070017_SRAM_RAND_DELAY_EN to add 0..7 pseudo-random extra wait cycles per
//           request, drawn from a 16-bit Fibonacci LFSR.
module ysyx_24070017_sram_responder #(
  parameter int                     WORD_LENGTH = 32,
  parameter int                     DEPTH_LOG2  = 12,
  parameter logic [WORD_LENGTH-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                     LATENCY     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_wen,
  input  logic [WORD_LENGTH-1:0] req_addr,
  input  logic [WORD_LENGTH-1:0] req_wdata,
  input  logic [3:0]             req_wmask,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WORD_LENGTH-1:0] rsp_rdata,
  output logic                   rsp_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, state_nxt;

  // Five bits covers LATENCY (max 15) plus up to 7 random extra cycles.
  logic [4:0] cnt;
  logic [4:0] load_val;

  logic                   l_wen;
  logic [WORD_LENGTH-1:0] l_addr;
  logic [WORD_LENGTH-1:0] l_wdata;
  logic [3:0]             l_wmask;

  logic accept;
  logic do_access;
  logic use_req;

  logic                   acc_wen;
  logic [WORD_LENGTH-1:0] acc_addr;
  logic [WORD_LENGTH-1:0] acc_wdata;
  logic [3:0]             acc_wmask;
  logic [WORD_LENGTH-3:0] word_off;
  logic [DEPTH_LOG2-1:0]  acc_idx;
  logic [1:0]             acc_off;
  logic                   in_range;
  logic [3:0]             lane_en;
  logic [WORD_LENGTH-1:0] wdata_sh;

  logic [WORD_LENGTH-1:0] mem [2**DEPTH_LOG2];

`ifdef YSYX_24070017_SRAM_RAND_DELAY_EN
  logic [15:0] lfsr;

  // Taps 16,14,13,11 (bits 15,13,12,10), shifting towards the MSB.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign load_val = 5'(LATENCY) + {2'b00, lfsr[2:0]};
`else
  assign load_val = 5'(LATENCY);
`endif

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The access happens either on the accept edge itself (zero wait) or on
  // the last WAIT cycle; use_req selects live request inputs for the former.
  always_comb begin
    state_nxt = state;
    do_access = 1'b0;
    use_req   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (load_val == 5'd0) begin
            do_access = 1'b1;
            use_req   = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt <= 5'd1) begin
          do_access = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= 5'd0;
      l_wen   <= 1'b0;
      l_addr  <= '0;
      l_wdata <= '0;
      l_wmask <= 4'd0;
    end else if (accept) begin
      cnt     <= load_val;
      l_wen   <= req_wen;
      l_addr  <= req_addr;
      l_wdata <= req_wdata;
      l_wmask <= req_wmask;
    end else if (state == WAIT) begin
      cnt <= cnt - 5'd1;
    end
  end

  assign acc_wen   = use_req ? req_wen   : l_wen;
  assign acc_addr  = use_req ? req_addr  : l_addr;
  assign acc_wdata = use_req ? req_wdata : l_wdata;
  assign acc_wmask = use_req ? req_wmask : l_wmask;

  // Word offset from the base; anything above the array depth is a miss,
  // and addresses below the base wrap to large values and miss as well.
  assign word_off = acc_addr[WORD_LENGTH-1:2] - BASE_ADDR[WORD_LENGTH-1:2];
  assign acc_idx  = word_off[DEPTH_LOG2-1:0];
  assign in_range = (word_off[WORD_LENGTH-3:DEPTH_LOG2] == '0);
  assign acc_off  = acc_addr[1:0];

  // Lanes pushed past byte 3 fall off the 4-bit mask: no cross-word writes.
  assign lane_en  = acc_wmask << acc_off;
  assign wdata_sh = acc_wdata << {acc_off, 3'b000};

  // Gated by rst so a store caught in WAIT by reset never lands.
  always_ff @(posedge clk) begin
    if (rst && do_access && acc_wen && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) begin
          mem[acc_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
        end
      end
    end
  end

  // Response registers only move on an access, so they hold through RESP.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (do_access) begin
      rsp_err   <= ~in_range;
      rsp_rdata <= (!acc_wen && in_range) ? (mem[acc_idx] >> {acc_off, 3'b000}) : '0;
    end
  end

endmodule

// File: tb/tb_ysyx_24070017_sram_responder.sv
// Purpose : randomized + directed bench for ysyx_24070017_sram_responder with a byte-level memory model.
// Latency : expects rsp_valid LATENCY+1 cycles after each accept (LATENCY+1..LATENCY+8 with random delay).
// Backpressure: rsp_ready is driven randomly or held low on demand to exercise response stalls.
module tb_ysyx_24070017_sram_responder;

  localparam int          LAT  = 1;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int unsigned SPAN = 4 * 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  ysyx_24070017_sram_responder #(
    .WORD_LENGTH(32),
    .DEPTH_LOG2 (12),
    .BASE_ADDR  (BASE),
    .LATENCY    (LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_wen  (req_wen),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_wmask(req_wmask),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  mdl [int unsigned];
  logic [1:0]  ready_ctl   = 2'd2;
  bit          expect_hold = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference model: byte-addressed storage relative to BASE.
  function automatic bit oor(input logic [31:0] a);
    return (a < BASE) || ((a - BASE) >= SPAN);
  endfunction

  task automatic mdl_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    int unsigned wb;
    int          off;
    wb  = (a - BASE) & 32'hFFFF_FFFC;
    off = int'(a[1:0]);
    for (int j = 0; j < 4; j++)
      if (m[j] && (off + j) < 4) mdl[wb + off + j] = d[8*j +: 8];
  endtask

  function automatic logic [31:0] mdl_load(input logic [31:0] a);
    int unsigned wb;
    int          off;
    logic [31:0] r;
    wb  = (a - BASE) & 32'hFFFF_FFFC;
    off = int'(a[1:0]);
    r   = 32'h0;
    for (int j = 0; j < 4 - off; j++)
      r[8*j +: 8] = mdl.exists(wb + off + j) ? mdl[wb + off + j] : 8'h00;
    return r;
  endfunction

  // Presents one request, waits for its accept edge, then records the
  // expected response. With fixed=1 the expectation is the given constant.
  task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wmask, input bit push = 1'b1, input bit fixed = 1'b0,
                       input logic [31:0] f_rdata = 32'h0, input logic f_err = 1'b0);
    exp_t e;
    int   t;
    @(negedge clk);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = wmask;
    t = 0;
    while (!req_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      fail_now("accept_timeout");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (push) begin
      e.err   = oor(addr);
      e.rdata = 32'h0;
      if (!e.err) begin
        if (wen) mdl_store(addr, wdata, wmask);
        else     e.rdata = mdl_load(addr);
      end
      if (fixed) begin
        e.rdata = f_rdata;
        e.err   = f_err;
      end
      e.acc_cyc = cyc;
      q.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (q.size() > 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (q.size() > 0) fail_now("drain_timeout");
  endtask

  // rsp_ready changes shortly after each rising edge so it is settled at the sample point.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      rsp_ready = (ready_ctl == 2'd2) ? ($urandom_range(0, 3) != 0) : ready_ctl[0];
    end
  end

  // Monitor: samples on the falling edge and checks against the queue head.
  bit          in_resp = 1'b0;
  bit          post_hs = 1'b0;
  logic [31:0] s_rdata;
  logic        s_err;
  int          held    = 0;
  int          lat;

  always @(negedge clk) begin
    if (!rst) begin
      in_resp = 1'b0;
      post_hs = 1'b0;
    end else if (post_hs) begin
      chk("idle_after_hs_req_ready", req_ready, 1);
      chk("idle_after_hs_rsp_valid", rsp_valid, 0);
      post_hs = 1'b0;
    end else if (rsp_valid) begin
      if (!in_resp) begin
        in_resp = 1'b1;
        held    = 0;
        s_rdata = rsp_rdata;
        s_err   = rsp_err;
        if (q.size() == 0) begin
          fail_now("unexpected_response");
        end else begin
          lat = cyc - q[0].acc_cyc + 1;
`ifdef YSYX_24070017_SRAM_RAND_DELAY_EN
          chk("rsp_latency_range", (lat >= LAT + 1 && lat <= LAT + 8), 1);
`else
          chk("rsp_latency", lat, LAT + 1);
`endif
        end
      end else begin
        chk("hold_rdata", rsp_rdata, s_rdata);
        chk("hold_err", rsp_err, s_err);
      end
      chk("req_ready_in_resp", req_ready, 0);
      if (rsp_ready) begin
        if (q.size() > 0) begin
          chk("rsp_rdata", rsp_rdata, q[0].rdata);
          chk("rsp_err", rsp_err, q[0].err);
          if (expect_hold) begin
            chk("hold_cycles", held, 5);
            expect_hold = 1'b0;
          end
          void'(q.pop_front());
        end
        in_resp = 1'b0;
        post_hs = 1'b1;
      end else begin
        held++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [31:0] a;
    logic [3:0]  m;

    rst       = 1'b0;
    req_valid = 1'b0;
    req_wen   = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_wmask = 4'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", req_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    rst = 1'b1;

    // Full-word store and readback.
    issue(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111);
    issue(1'b0, 32'h8000_0010, 32'h0, 4'h0, 1, 1, 32'hDEAD_BEEF, 1'b0);
    // Byte store at offset 3, then aligned and unaligned loads.
    issue(1'b1, 32'h8000_0013, 32'h0000_005A, 4'b0001);
    issue(1'b0, 32'h8000_0010, 32'h0, 4'h0, 1, 1, 32'h5AAD_BEEF, 1'b0);
    issue(1'b0, 32'h8000_0013, 32'h0, 4'h0, 1, 1, 32'h0000_005A, 1'b0);
    // Out-of-range on both sides, then array unchanged.
    issue(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 1, 1, 32'h0, 1'b1);
    issue(1'b0, 32'h8000_4000, 32'h0, 4'h0, 1, 1, 32'h0, 1'b1);
    issue(1'b0, 32'h8000_0010, 32'h0, 4'h0, 1, 1, 32'h5AAD_BEEF, 1'b0);
    // Last word, and a store just past the end must not alias word 0.
    issue(1'b1, 32'h8000_0000, 32'h0123_4567, 4'b1111);
    issue(1'b1, 32'h8000_3FFC, 32'hCAFE_F00D, 4'b1111);
    issue(1'b0, 32'h8000_3FFC, 32'h0, 4'h0, 1, 1, 32'hCAFE_F00D, 1'b0);
    issue(1'b1, 32'h8000_4000, 32'hBAD0_BAD0, 4'b1111, 1, 1, 32'h0, 1'b1);
    issue(1'b0, 32'h8000_0000, 32'h0, 4'h0, 1, 1, 32'h0123_4567, 1'b0);
    issue(1'b0, 32'h8000_3FFC, 32'h0, 4'h0, 1, 1, 32'hCAFE_F00D, 1'b0);
    wait_drain();

    // Hold rsp_ready low for 5 sampled RESP cycles, handshake on the 6th.
    ready_ctl   = 2'd0;
    expect_hold = 1'b1;
    issue(1'b0, 32'h8000_0010, 32'h0, 4'h0, 1, 1, 32'h5AAD_BEEF, 1'b0);
    @(negedge clk);
    t = 0;
    while (!rsp_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!rsp_valid) fail_now("hold_rsp_timeout");
    repeat (4) @(negedge clk);
    ready_ctl = 2'd1;
    wait_drain();
    ready_ctl = 2'd2;

    // Reset while a store sits in WAIT: it must be dropped entirely.
    issue(1'b1, 32'h8000_0020, 32'h1111_1111, 4'b1111);
    wait_drain();
    issue(1'b1, 32'h8000_0020, 32'h2222_2222, 4'b1111, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_req_ready", req_ready, 1);
    chk("midreset_rsp_valid", rsp_valid, 0);
    repeat (10) @(negedge clk);
    issue(1'b0, 32'h8000_0020, 32'h0, 4'h0, 1, 1, 32'h1111_1111, 1'b0);
    wait_drain();

    // Randomized traffic over a 16-word window plus occasional misses.
    for (int w = 0; w < 16; w++)
      issue(1'b1, BASE + 32'(4 * w), $urandom, 4'b1111);
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       a = 32'h7FFF_FFFC;
          1:       a = 32'h8000_4000 + 32'($urandom_range(0, 3));
          2:       a = 32'h0000_1000;
          default: a = 32'hFFFF_FFF0;
        endcase
      end else begin
        a = BASE + 32'($urandom_range(0, 63));
      end
      case ($urandom_range(0, 3))
        0:       m = 4'b0001;
        1:       m = 4'b0011;
        2:       m = 4'b1111;
        default: m = 4'($urandom);
      endcase
      issue(1'($urandom), a, $urandom, m);
    end
    wait_drain();
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_24070017_sram_responder.md
Name: ysyx_24070017_sram_responder

Overview:
- Memory-side responder for the core's load/store port. It completes the request/response protocol that the CPU initiates.
- Accepts one request at a time on a valid/ready request channel and holds it for a programmable latency. It then returns read data, or a write acknowledge, on a valid/ready response channel.
- Backed by an internal word-organised SRAM array mapped at BASE_ADDR. This replaces the direct DPI pmem access for synthesizable builds.

Parameters:
- WORD_LENGTH, 32, data/address width in bits.
- DEPTH_LOG2, 12, log2 of the number of 32-bit words in the array (4096 words = 16 KiB).
- BASE_ADDR, 32'h80000000, byte address of word 0.
- LATENCY, 1, cycles spent in WAIT before the response is presented; legal range 0..15.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-low (rst==0 at a rising edge resets).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_wen  in  1  1 = store, 0 = load.
- req_addr  in  WORD_LENGTH  byte address.
- req_wdata  in  WORD_LENGTH  store data, right-aligned (byte 0 = bits 7:0).
- req_wmask  in  4  store byte mask, right-aligned (8'b0001/0011/1111 style narrowed to 4 bits).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts response.
- rsp_rdata  out  WORD_LENGTH  load data, right-aligned to req_addr[1:0].
- rsp_err  out  1  address outside [BASE_ADDR, BASE_ADDR + 4*2^DEPTH_LOG2).

Behaviour:
- States: IDLE, WAIT, RESP. Reset drives state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, delay counter=0. Array contents are not reset.
- Reset mid-operation: any request in WAIT/RESP is dropped; a pending store in WAIT must not reach the array.
- req_ready = (state==IDLE). A request is accepted on req_valid && req_ready. Accepting it latches wen, addr, wdata, wmask and loads the counter with LATENCY.
- IDLE -> WAIT on accept when LATENCY>0. IDLE -> RESP directly when LATENCY==0, with the response valid the cycle after accept.
- WAIT: the counter decrements each cycle. At counter==1 the access is performed and the state moves to RESP, so rsp_valid rises exactly LATENCY+1 cycles after the accept edge (LATENCY==0 gives 1).
- Index = (addr - BASE_ADDR) >> 2, truncated to DEPTH_LOG2 bits. off = addr[1:0].
- Store: the lanes enabled by (wmask << off) are written with (wdata << 8*off). Lanes shifted past bit 31 are discarded; there is no cross-word write.
- Load: rsp_rdata = word[index] >> 8*off, zero-filled on the left.
- A store response has rsp_rdata = 0.
- Out-of-range address: no array access, rsp_rdata = 0, rsp_err = 1; otherwise rsp_err = 0.
- RESP: rsp_valid=1, and rsp_rdata/rsp_err are held stable until rsp_valid && rsp_ready. On that handshake the state returns to IDLE and rsp_valid drops next cycle.
- No back-to-back overlap: the next request is accepted no earlier than the cycle after the response handshake.
- req_valid while not ready is ignored; the requester must hold the request stable.
- Stores are visible to any load accepted after the store's response handshake.

Optional Feature:
- Macro: YSYX_24070017_SRAM_RAND_DELAY_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle. On accept the counter loads LATENCY + lfsr[2:0], giving 0..7 extra cycles. This exercises requester tolerance of variable latency.
- Not defined: fixed LATENCY, and no LFSR logic is present.

Test Plan:
- Reset with rst=0 for 2 cycles -> req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0.
- Store addr 0x80000010, wdata 0xDEADBEEF, wmask 4'b1111, LATENCY=1, then load 0x80000010 -> rsp_valid 2 cycles after each accept, load rsp_rdata=0xDEADBEEF, rsp_err=0.
- Store byte 0x5A at 0x80000013 (wmask 4'b0001), then load 0x80000010 and 0x80000013 -> 0x5AADBEEF and 0x0000005A.
- Load 0x7FFFFFFC and 0x80004000 -> rsp_err=1, rsp_rdata=0, array unchanged.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata, rsp_err stable and req_ready=0 throughout; handshake on the 6th cycle -> IDLE next cycle.
- Assert rst=0 while in WAIT on a store to 0x80000020 (prior value 0x11111111) -> state IDLE, no response, later load returns 0x11111111.
